// File: rtl/fft_result_collector_if.sv
// Handshake/data bundle between the FFT core, the result collector and the display stage.
interface fft_result_collector_if #(
  parameter int unsigned bit_width = 32
);
  localparam int unsigned CNT_W = 26;

  logic                        start;
  logic                        in_valid;
  logic signed [bit_width-1:0] x_in;
  logic signed [bit_width-1:0] y_in;
  logic                        en_seg7;
  logic signed [bit_width-1:0] x_out;
  logic signed [bit_width-1:0] y_out;
  logic [CNT_W-1:0]            count;
  logic                        busy;
  logic                        drop;
  logic                        sat;

  modport master (
    output start, in_valid, x_in, y_in,
    input  en_seg7, x_out, y_out, count, busy, drop, sat
  );

  modport slave (
    input  start, in_valid, x_in, y_in,
    output en_seg7, x_out, y_out, count, busy, drop, sat
  );
endinterface

// File: rtl/fft_result_collector.sv
// Captures one bit-reversed FFT frame into natural order, measures start-to-last-sample
// latency, and replays the frame to the display as an N-cycle burst.
module fft_result_collector #(
  parameter int unsigned bit_width = 32,
  parameter int unsigned N         = 16,
  parameter int unsigned SIZE      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_result_collector_if.slave bus
);

  localparam int unsigned CNT_W = 26;
  localparam logic [CNT_W-1:0] LAT_MAX = '1;
  localparam logic [SIZE-1:0]  LAST_IDX = SIZE'(N - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, REPLAY} state_e;

  typedef struct packed {
    logic signed [bit_width-1:0] x;
    logic signed [bit_width-1:0] y;
  } sample_t;

  state_e                      state_q, state_d;
  logic [SIZE-1:0]             wr_ptr_q, wr_ptr_d;
  logic [SIZE-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            lat_q, lat_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        en_q, en_d;
  logic signed [bit_width-1:0] x_q, x_d;
  logic signed [bit_width-1:0] y_q, y_d;
  logic                        busy_q, busy_d;
  logic                        drop_q, drop_d;
  logic                        sat_q, sat_d;
  logic                        we_c;
  logic [SIZE-1:0]             waddr_c;
  sample_t                     rdata_c;

  sample_t mem_q [N];

  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] a);
    logic [SIZE-1:0] r;
    r = '0;
    for (int b = 0; b < int'(SIZE); b++) r[b] = a[int'(SIZE) - 1 - b];
    return r;
  endfunction

  assign rdata_c = mem_q[rd_ptr_q];

  // Next-state and output computation
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lat_d    = lat_q;
    count_d  = count_q;
    en_d     = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    drop_d   = drop_q;
    sat_d    = sat_q;
    we_c     = 1'b0;
    waddr_c  = bitrev(wr_ptr_q);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          lat_d    = '0;
          wr_ptr_d = '0;
          drop_d   = 1'b0;
          sat_d    = 1'b0;
          state_d  = MEASURE;
        end else if (bus.in_valid) begin
          drop_d = 1'b1;
        end
      end
      MEASURE: begin
        if (bus.start) begin
          lat_d    = '0;
          wr_ptr_d = '0;
          drop_d   = 1'b0;
          sat_d    = 1'b0;
        end else begin
          // Saturating latency counter; sat flags that the true latency was lost
          lat_d = (lat_q == LAT_MAX) ? LAT_MAX : lat_q + CNT_W'(1);
          if (lat_d == LAT_MAX) sat_d = 1'b1;
          if (bus.in_valid) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + SIZE'(1);
            if (wr_ptr_q == LAST_IDX) begin
              count_d  = lat_d;
              rd_ptr_d = '0;
              state_d  = REPLAY;
            end
          end
        end
      end
      REPLAY: begin
        en_d     = 1'b1;
        x_d      = rdata_c.x;
        y_d      = rdata_c.y;
        rd_ptr_d = rd_ptr_q + SIZE'(1);
        if (rd_ptr_q == LAST_IDX) state_d = IDLE;
        if (bus.in_valid) drop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lat_q    <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lat_q    <= lat_d;
      count_q  <= count_d;
      en_q     <= en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      sat_q    <= sat_d;
    end
  end

  // Frame storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we_c) mem_q[waddr_c] <= sample_t'{x: bus.x_in, y: bus.y_in};
  end

  assign bus.en_seg7 = en_q;
  assign bus.x_out   = x_q;
  assign bus.y_out   = y_q;
  assign bus.count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.drop    = drop_q;
  assign bus.sat     = sat_q;

endmodule

// File: tb/tb_fft_result_collector.sv
// Self-checking bench for fft_result_collector: reference model is a natural-order array
// filled via integer bit reversal plus a cycle-count latency measured by the bench.
module tb_fft_result_collector;

  localparam int unsigned BW = 32;
  localparam int unsigned NP = 16;
  localparam int unsigned SZ = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fft_result_collector_if #(.bit_width(BW)) bus ();

  fft_result_collector #(.bit_width(BW), .N(NP), .SIZE(SZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic signed [BW-1:0] exp_x [NP];
  logic signed [BW-1:0] exp_y [NP];
  logic [25:0]          exp_count;

  function automatic int brev(input int i);
    int r;
    r = 0;
    for (int b = 0; b < int'(SZ); b++)
      if (((i >> b) & 1) != 0) r = r + (1 << (int'(SZ) - 1 - b));
    return r;
  endfunction

  // One clock cycle: inputs applied, then outputs settle at the following falling edge
  task automatic drive(input logic s, input logic v, input logic signed [BW-1:0] x,
                       input logic signed [BW-1:0] y);
    bus.start    = s;
    bus.in_valid = v;
    bus.x_in     = x;
    bus.y_in     = y;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, BW'($urandom), BW'($urandom));
  endtask

  // Start pulse at relative cycle 0, then n samples; gaps forced for rel<=lead or in [gap_lo,gap_hi]
  task automatic do_frame(input int n, input int lead, input int gap_lo, input int gap_hi,
                          input int gap_pct, input bit fixed);
    int c0, i, rel;
    logic signed [BW-1:0] x, y;
    c0 = cyc;
    drive(1'b1, 1'b0, BW'($urandom), BW'($urandom));
    i = 0;
    while (i < n) begin
      rel = cyc - c0;
      if (rel <= lead || (rel >= gap_lo && rel <= gap_hi) || int'($urandom_range(99)) < gap_pct) begin
        idle();
      end else begin
        if (fixed) begin
          x = BW'(brev(i) * 3);
          y = BW'(-brev(i));
        end else begin
          x = BW'($urandom);
          y = BW'($urandom);
        end
        exp_x[brev(i)] = x;
        exp_y[brev(i)] = y;
        if (i == n - 1) exp_count = 26'(rel);
        drive(1'b0, 1'b1, x, y);
        i++;
      end
    end
  endtask

  // Called right after the last sample's edge; checks the full replay burst
  task automatic check_burst(input string tag, input int inj_v, input int inj_s);
    checks++;
    if (bus.en_seg7 !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_entry en_seg7=%b busy=%b required en_seg7=0 busy=1", tag, bus.en_seg7, bus.busy);
    end
    idle();
    for (int k = 0; k < int'(NP); k++) begin
      checks++;
      if (bus.en_seg7 !== 1'b1 || bus.x_out !== exp_x[k] || bus.y_out !== exp_y[k] ||
          bus.count !== exp_count) begin
        failures++;
        $display("FAIL %s_burst k=%0d en=%b x=%0d y=%0d count=%0d required en=1 x=%0d y=%0d count=%0d",
                 tag, k, bus.en_seg7, bus.x_out, bus.y_out, bus.count, exp_x[k], exp_y[k], exp_count);
      end
      drive(k == inj_s, k == inj_v, BW'($urandom), BW'($urandom));
    end
    checks++;
    if (bus.en_seg7 !== 1'b0 || bus.busy !== 1'b0 || bus.x_out !== exp_x[NP-1] ||
        bus.y_out !== exp_y[NP-1] || bus.count !== exp_count) begin
      failures++;
      $display("FAIL %s_exit en=%b busy=%b x=%0d y=%0d count=%0d required en=0 busy=0 x=%0d y=%0d count=%0d",
               tag, bus.en_seg7, bus.busy, bus.x_out, bus.y_out, bus.count,
               exp_x[NP-1], exp_y[NP-1], exp_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.x_in = '0; bus.y_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) idle();
    checks++;
    if (bus.en_seg7 !== 1'b0 || bus.x_out !== '0 || bus.y_out !== '0 || bus.count !== '0 ||
        bus.busy !== 1'b0 || bus.drop !== 1'b0 || bus.sat !== 1'b0) begin
      failures++;
      $display("FAIL reset en=%b x=%0d y=%0d count=%0d busy=%b drop=%b sat=%b required all 0",
               bus.en_seg7, bus.x_out, bus.y_out, bus.count, bus.busy, bus.drop, bus.sat);
    end
  endtask

  task automatic test_basic();
    do_frame(NP, 4, -1, -1, 0, 1'b1);
    check_burst("basic", -1, -1);
    checks++;
    if (bus.count !== 26'd20) begin
      failures++;
      $display("FAIL basic_count count=%0d required 20", bus.count);
    end
  endtask

  task automatic test_gaps();
    do_frame(NP, 4, 10, 12, 0, 1'b1);
    check_burst("gaps", -1, -1);
    checks++;
    if (bus.count !== 26'd23) begin
      failures++;
      $display("FAIL gaps_count count=%0d required 23", bus.count);
    end
  endtask

  task automatic test_restart();
    int c0;
    c0 = cyc;
    do_frame(8, 4, -1, -1, 0, 1'b0);
    while (cyc - c0 < 15) idle();
    checks++;
    if (bus.en_seg7 !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_partial en=%b busy=%b required en=0 busy=1", bus.en_seg7, bus.busy);
    end
    do_frame(NP, 2, -1, -1, 20, 1'b0);
    check_burst("restart", -1, -1);
  endtask

  task automatic test_drop();
    drive(1'b0, 1'b1, BW'($urandom), BW'($urandom));
    checks++;
    if (bus.drop !== 1'b1 || bus.busy !== 1'b0 || bus.en_seg7 !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle drop=%b busy=%b en=%b required drop=1 busy=0 en=0", bus.drop, bus.busy, bus.en_seg7);
    end
    do_frame(NP, 1, -1, -1, 15, 1'b0);
    checks++;
    if (bus.drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_cleared drop=%b required 0", bus.drop);
    end
    // Stray sample and an ignored start both land inside the burst
    check_burst("drop", 5, 9);
    checks++;
    if (bus.drop !== 1'b1) begin
      failures++;
      $display("FAIL drop_replay drop=%b required 1", bus.drop);
    end
    drive(1'b1, 1'b0, '0, '0);
    checks++;
    if (bus.drop !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_restart drop=%b busy=%b required drop=0 busy=1", bus.drop, bus.busy);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 3)) idle();
      do_frame(NP, int'($urandom_range(0, 3)), -1, -1, 25, 1'b0);
      check_burst("random", -1, -1);
      checks++;
      if (bus.sat !== 1'b0 || bus.drop !== 1'b0) begin
        failures++;
        $display("FAIL random_flags sat=%b drop=%b required sat=0 drop=0", bus.sat, bus.drop);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int stray;
    do_frame(NP, 0, -1, -1, 10, 1'b0);
    idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.en_seg7 !== 1'b1 || bus.x_out !== exp_x[k] || bus.y_out !== exp_y[k]) begin
        failures++;
        $display("FAIL rstmid_burst k=%0d en=%b x=%0d y=%0d required en=1 x=%0d y=%0d",
                 k, bus.en_seg7, bus.x_out, bus.y_out, exp_x[k], exp_y[k]);
      end
      if (k < 3) idle();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.en_seg7 !== 1'b0 || bus.count !== '0 || bus.busy !== 1'b0 ||
        bus.x_out !== '0 || bus.y_out !== '0) begin
      failures++;
      $display("FAIL rstmid_async en=%b count=%0d busy=%b x=%0d y=%0d required all 0",
               bus.en_seg7, bus.count, bus.busy, bus.x_out, bus.y_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (24) begin
      idle();
      if (bus.en_seg7 !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rstmid_quiet active_cycles=%0d required 0", stray);
    end
    do_frame(NP, 3, -1, -1, 20, 1'b0);
    check_burst("rstmid_next", -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_restart();
    test_drop();
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
